predecode_queue: RTL and testbench

//  Multi-lane instruction buffer between fetch and decode/issue. Accepts up to LANES fetched words
//  per cycle, predecodes each on entry, and issues up to LANES oldest entries per cycle in order.

---
 rtl/predecode_queue_if.sv | 25 ++
 rtl/predecode_queue.sv | 121 ++++++++++++
 tb/tb_predecode_queue.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/predecode_queue_if.sv
// predecode_queue_if: push (fetch) and pop (issue) lanes of the predecode queue
interface predecode_queue_if #(parameter int LANES = 2);
    logic [LANES-1:0]   in_valid;
    logic [32*LANES-1:0] in_instr;
    logic [32*LANES-1:0] in_pc;
    logic               in_ready;
    logic [LANES-1:0]   out_valid;
    logic [LANES-1:0]   out_ready;
    logic [32*LANES-1:0] out_instr;
    logic [32*LANES-1:0] out_pc;
    logic [3*LANES-1:0] out_branch_type;
    logic [LANES-1:0]   out_is_branch;
    logic [LANES-1:0]   out_is_link;
    logic [LANES-1:0]   out_is_hilo;
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_branch_type,
               out_is_branch, out_is_link, out_is_hilo
    );
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_branch_type,
               out_is_branch, out_is_link, out_is_hilo
    );
endinterface

// File: rtl/predecode_queue.sv
// predecode_queue: multi-lane in-order instruction buffer with predecode on entry; PREDECODE_QUEUE_BYPASS_EN enables same-cycle empty-queue bypass
`ifndef B_INVA
`define B_INVA 3'd0
`define B_EQNE 3'd1
`define B_LTGE 3'd2
`define B_JUMP 3'd3
`define B_JREG 3'd4
`endif
module predecode_queue #(
    parameter int DEPTH = 8,
    parameter int LANES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    predecode_queue_if.slave             q,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    typedef struct packed {
        logic [2:0] btype;
        logic       br;
        logic       link;
        logic       hilo;
    } pd_t;
    function automatic pd_t predecode(input logic [31:0] w);
        pd_t p;
        logic [5:0] op;
        logic [4:0] rt;
        logic [5:0] fn;
        op = w[31:26];
        rt = w[20:16];
        fn = w[5:0];
        p.btype = (op[5:2] == 4'b0001) ? `B_EQNE :
                  (op == 6'b000001 && rt[3:1] == 3'b000) ? `B_LTGE :
                  (op[5:1] == 5'b00001) ? `B_JUMP :
                  (op == 6'd0 && fn[5:1] == 5'b00100) ? `B_JREG : `B_INVA;
        p.br   = p.btype != `B_INVA;
        p.link = (p.btype == `B_LTGE) ? rt[4] :
                 (p.btype == `B_JUMP) ? op[0] :
                 (p.btype == `B_JREG) ? fn[0] : 1'b0;
        p.hilo = (op == 6'd0 && (fn[5:2] == 4'b0100 || fn[5:2] == 4'b0110)) ||
                 (op == 6'b011100 && fn[5:3] == 3'b000 && fn[2:0] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return p;
    endfunction
    logic [31:0]       instr_mem [DEPTH];
    logic [31:0]       pc_mem    [DEPTH];
    pd_t               pd_mem    [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic              in_rdy, byp;
    logic [CW-1:0]     pushes, pops, skip;
    logic [LANES-1:0]  ov, wen;
    logic [PW-1:0]     waddr [LANES];
    pd_t               in_pd [LANES];
    logic [32*LANES-1:0] o_instr, o_pc;
    logic [3*LANES-1:0]  o_type;
    logic [LANES-1:0]    o_br, o_link, o_hilo;
    // admission, lane selection (storage or bypass), pop/push counts and write slots
    always_comb begin
        in_rdy = !rst && !flush && (CW'(DEPTH) - occupancy >= CW'(LANES));
`ifdef PREDECODE_QUEUE_BYPASS_EN
        byp = !rst && !flush && occupancy == '0;
`else
        byp = 1'b0;
`endif
        pushes = '0;
        pops = '0;
        o_instr = '0;
        o_pc = '0;
        o_type = '0;
        o_br = '0;
        o_link = '0;
        o_hilo = '0;
        ov = '0;
        for (int i = 0; i < LANES; i++) begin
            in_pd[i] = predecode(q.in_instr[32*i +: 32]);
            ov[i] = byp ? (q.in_valid[i] & in_rdy) : ((occupancy > CW'(i)) & !flush & !rst);
            o_instr[32*i +: 32] = byp ? q.in_instr[32*i +: 32] : instr_mem[rd_ptr + PW'(i)];
            o_pc[32*i +: 32]    = byp ? q.in_pc[32*i +: 32] : pc_mem[rd_ptr + PW'(i)];
            {o_type[3*i +: 3], o_br[i], o_link[i], o_hilo[i]} = byp ? in_pd[i] : pd_mem[rd_ptr + PW'(i)];
            pushes = pushes + CW'(q.in_valid[i] & in_rdy);
            pops = pops + CW'(ov[i] & q.out_ready[i]);
        end
        skip = byp ? pops : '0;
        for (int i = 0; i < LANES; i++) begin
            wen[i] = q.in_valid[i] & in_rdy & (CW'(i) >= skip);
            waddr[i] = wr_ptr + PW'(CW'(i) - skip);
        end
    end
    assign q.in_ready        = in_rdy;
    assign q.out_valid       = ov;
    assign q.out_instr       = o_instr;
    assign q.out_pc          = o_pc;
    assign q.out_branch_type = o_type;
    assign q.out_is_branch   = o_br;
    assign q.out_is_link     = o_link;
    assign q.out_is_hilo     = o_hilo;
    // pointers and count; reset and flush both clear them, storage stays stale
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            rd_ptr    <= rd_ptr + PW'(pops - skip);
            wr_ptr    <= wr_ptr + PW'(pushes - skip);
            occupancy <= occupancy + pushes - pops;
        end
    end
    // write accepted, not-bypassed lanes with their predecode into consecutive slots
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wen[i]) begin
                instr_mem[waddr[i]] <= q.in_instr[32*i +: 32];
                pc_mem[waddr[i]]    <= q.in_pc[32*i +: 32];
                pd_mem[waddr[i]]    <= in_pd[i];
            end
        end
    end
endmodule

// File: tb/tb_predecode_queue.sv
// tb_predecode_queue: queue model + per-cycle compare, with directed literal checks
module tb_predecode_queue;
    localparam int L = 2;
    localparam int D = 8;
    localparam logic [2:0] INVA = 3'd0, EQNE = 3'd1, LTGE = 3'd2, JUMP = 3'd3, JREG = 3'd4;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [3:0] occupancy;
    int checks = 0;
    int errors = 0;
    ent_t mq[$];
    logic [31:0] tbl [8];
    predecode_queue_if #(.LANES(L)) q();
    predecode_queue #(.DEPTH(D), .LANES(L)) dut (
        .clk(clk), .rst(rst), .flush(flush), .q(q), .occupancy(occupancy)
    );
    always #5 clk = ~clk;
    initial begin
        tbl[0] = 32'h10220003; tbl[1] = 32'h0C000010; tbl[2] = 32'h00004010; tbl[3] = 32'h70220000;
        tbl[4] = 32'h70221002; tbl[5] = 32'h0040F809; tbl[6] = 32'h04110004; tbl[7] = 32'h00221021;
    end
    function automatic logic [31:0] pcof(input int k);
        return 32'h1000 + 32'(4 * k);
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask
    // reference predecode: {type, branch, link, hilo}
    function automatic logic [5:0] ref_pd(input logic [31:0] w);
        int op, rt, fn;
        logic [2:0] t;
        logic lk, hl;
        op = int'(w[31:26]);
        rt = int'(w[20:16]);
        fn = int'(w[5:0]);
        lk = 1'b0;
        if (op inside {4, 5, 6, 7}) t = EQNE;
        else if (op == 1 && rt inside {0, 1, 16, 17}) begin t = LTGE; lk = rt >= 16; end
        else if (op == 2 || op == 3) begin t = JUMP; lk = op == 3; end
        else if (op == 0 && fn inside {8, 9}) begin t = JREG; lk = fn == 9; end
        else t = INVA;
        hl = (op == 0 && fn inside {[16:19], [24:27]}) || (op == 28 && fn inside {0, 1, 2, 4, 5});
        return {t, t != INVA, lk, hl};
    endfunction
    always @(posedge clk) begin
        int n, pops;
        bit rdy, byp;
        if (rst || flush) mq.delete();
        else begin
            n = mq.size();
            rdy = (D - n) >= L;
            byp = 1'b0;
`ifdef PREDECODE_QUEUE_BYPASS_EN
            byp = n == 0;
`endif
            pops = 0;
            if (byp) begin
                for (int i = 0; i < L; i++) if (q.in_valid[i] && q.out_ready[i]) pops++;
            end else begin
                for (int i = 0; i < L; i++) if (q.out_ready[i] && i < n) pops++;
                repeat (pops) void'(mq.pop_front());
                pops = 0;
            end
            if (rdy)
                for (int i = 0; i < L; i++)
                    if (q.in_valid[i] && i >= pops) mq.push_back({q.in_instr[32*i +: 32], q.in_pc[32*i +: 32]});
        end
    end
    always @(negedge clk) begin
        int n;
        bit byp, rdy, ev;
        logic [31:0] ei, ep;
        logic [5:0] pd;
        if (!rst) begin
            n = mq.size();
            byp = 1'b0;
`ifdef PREDECODE_QUEUE_BYPASS_EN
            byp = n == 0 && !flush;
`endif
            rdy = !flush && (D - n) >= L;
            chk("in_ready", 64'(q.in_ready), 64'(rdy));
            chk("occupancy", 64'(occupancy), 64'(n));
            for (int i = 0; i < L; i++) begin
                ev = byp ? (q.in_valid[i] && rdy) : (!flush && i < n);
                chk("out_valid", 64'(q.out_valid[i]), 64'(ev));
                if (ev) begin
                    ei = byp ? q.in_instr[32*i +: 32] : mq[i].instr;
                    ep = byp ? q.in_pc[32*i +: 32] : mq[i].pc;
                    pd = ref_pd(ei);
                    chk("out_instr", 64'(q.out_instr[32*i +: 32]), 64'(ei));
                    chk("out_pc", 64'(q.out_pc[32*i +: 32]), 64'(ep));
                    chk("out_branch_type", 64'(q.out_branch_type[3*i +: 3]), 64'(pd[5:3]));
                    chk("out_is_branch", 64'(q.out_is_branch[i]), 64'(pd[2]));
                    chk("out_is_link", 64'(q.out_is_link[i]), 64'(pd[1]));
                    chk("out_is_hilo", 64'(q.out_is_hilo[i]), 64'(pd[0]));
                end
            end
        end
    end
    task automatic cyc(input logic [1:0] v, input logic [1:0] ordy, input bit fl, input int k);
        q.in_valid = v;
        q.out_ready = ordy;
        flush = fl;
        q.in_instr = {tbl[(k + 1) % 8], tbl[k % 8]};
        q.in_pc = {pcof(k + 1), pcof(k)};
        @(posedge clk);
        #1;
        q.in_valid = '0;
        q.out_ready = '0;
        flush = 1'b0;
    endtask
    initial begin
        q.in_valid = '0;
        q.out_ready = '0;
        q.in_instr = '0;
        q.in_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_valid", 64'(q.out_valid), 64'd0);
        chk("rst_in_ready", 64'(q.in_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(q.in_ready), 64'd1);
        cyc(2'b11, 2'b00, 0, 0);
        chk("push2_out_valid", 64'(q.out_valid), 64'h3);
        chk("beq_type", 64'(q.out_branch_type[2:0]), 64'(EQNE));
        chk("jal_type", 64'(q.out_branch_type[5:3]), 64'(JUMP));
        chk("push2_link", 64'(q.out_is_link), 64'h2);
        chk("push2_occupancy", 64'(occupancy), 64'd2);
        cyc(2'b11, 2'b00, 0, 2);
        cyc(2'b11, 2'b00, 0, 4);
        cyc(2'b01, 2'b00, 0, 6);
        chk("occ7_in_ready", 64'(q.in_ready), 64'd0);
        chk("occ7_occupancy", 64'(occupancy), 64'd7);
        cyc(2'b11, 2'b00, 0, 8);
        chk("occ7_ignored", 64'(occupancy), 64'd7);
        cyc(2'b00, 2'b01, 0, 0);
        cyc(2'b11, 2'b00, 0, 10);
        chk("full_occupancy", 64'(occupancy), 64'd8);
        chk("full_in_ready", 64'(q.in_ready), 64'd0);
        cyc(2'b11, 2'b00, 0, 12);
        chk("full_ignored", 64'(occupancy), 64'd8);
        cyc(2'b00, 2'b11, 0, 0);
        chk("pop2_occupancy", 64'(occupancy), 64'd6);
        chk("pop2_in_ready", 64'(q.in_ready), 64'd1);
        chk("pop2_lane0_pc", 64'(q.out_pc[31:0]), 64'h100C);
        for (int j = 0; j < 6; j++) cyc(2'b11, 2'b11, 0, 20 + 2 * j);
        cyc(2'b00, 2'b11, 0, 0);
        chk("occ4", 64'(occupancy), 64'd4);
        cyc(2'b11, 2'b01, 0, 40);
        chk("push2pop1_occupancy", 64'(occupancy), 64'd5);
        chk("push2pop1_lane0_pc", 64'(q.out_pc[31:0]), 64'h1074);
        cyc(2'b00, 2'b11, 0, 0);
        cyc(2'b00, 2'b11, 0, 0);
        cyc(2'b00, 2'b01, 0, 0);
        chk("drained", 64'(occupancy), 64'd0);
        cyc(2'b11, 2'b00, 0, 2);
        chk("mfhi_madd_hilo", 64'(q.out_is_hilo), 64'h3);
        chk("mfhi_madd_branch", 64'(q.out_is_branch), 64'h0);
        cyc(2'b11, 2'b11, 0, 4);
        chk("mul_jalr_hilo", 64'(q.out_is_hilo), 64'h1);
        chk("jalr_type", 64'(q.out_branch_type[5:3]), 64'(JREG));
        chk("mul_jalr_link", 64'(q.out_is_link), 64'h2);
        cyc(2'b11, 2'b11, 0, 6);
        chk("bgezal_type", 64'(q.out_branch_type[2:0]), 64'(LTGE));
        chk("addu_type", 64'(q.out_branch_type[5:3]), 64'(INVA));
        chk("bgezal_addu_link", 64'(q.out_is_link), 64'h1);
        chk("bgezal_addu_branch", 64'(q.out_is_branch), 64'h1);
        chk("bgezal_addu_hilo", 64'(q.out_is_hilo), 64'h0);
        cyc(2'b11, 2'b00, 0, 50);
        cyc(2'b01, 2'b00, 0, 52);
        chk("preflush_occupancy", 64'(occupancy), 64'd5);
        cyc(2'b11, 2'b11, 1, 54);
        chk("flush_occupancy", 64'(occupancy), 64'd0);
        chk("flush_out_valid", 64'(q.out_valid), 64'd0);
        cyc(2'b11, 2'b00, 0, 0);
        chk("postflush_lane0", 64'(q.out_instr[31:0]), 64'h10220003);
        cyc(2'b00, 2'b11, 0, 0);
`ifdef PREDECODE_QUEUE_BYPASS_EN
        q.in_valid = 2'b11;
        q.out_ready = 2'b01;
        q.in_instr = {tbl[3], tbl[2]};
        q.in_pc = {pcof(3), pcof(2)};
        #2;
        chk("bypass_out_valid", 64'(q.out_valid), 64'h3);
        chk("bypass_lane0", 64'(q.out_instr[31:0]), 64'h00004010);
        @(posedge clk);
        #1;
        q.in_valid = '0;
        q.out_ready = '0;
        chk("bypass_occupancy", 64'(occupancy), 64'd1);
        chk("bypass_stored", 64'(q.out_instr[31:0]), 64'h70220000);
        cyc(2'b00, 2'b01, 0, 0);
`endif
        for (int j = 0; j < 150; j++) begin
            logic [1:0] v, r;
            v = ($urandom_range(0, 2) == 0) ? 2'b00 : ($urandom_range(0, 1) == 0 ? 2'b01 : 2'b11);
            r = ($urandom_range(0, 2) == 0) ? 2'b00 : ($urandom_range(0, 1) == 0 ? 2'b01 : 2'b11);
            cyc(v, r, $urandom_range(0, 19) == 0, int'($urandom_range(0, 999)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
